// File: rtl/level_ctrl_pkg.sv
// Shared types and defaults for the ADC level-sampling controller.
package level_ctrl_pkg;

    localparam int W_DEF       = 12;
    localparam int CONFIRM_DEF = 2;
    localparam int TO_CYC_DEF  = 255;
    localparam int PER_W       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        REQ  = 2'd2,
        EVAL = 2'd3
    } state_t;

    // A period of 0 behaves as 1, so the reload never underflows.
    function automatic logic [PER_W-1:0] period_reload(input logic [PER_W-1:0] period);
        return (period == '0) ? '0 : period - 1'b1;
    endfunction

endpackage

// File: rtl/level_tick_gen.sv
// Loadable 16-bit down-counter with zero flag; paces the WAIT interval.
module level_tick_gen
    import level_ctrl_pkg::*;
(
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_LOAD,
    input  logic [PER_W-1:0] i_VAL,
    input  logic             i_DEC,
    output logic             o_ZERO
);

    logic [PER_W-1:0] cnt_q;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST)
            cnt_q <= '0;
        else if (i_LOAD)
            cnt_q <= i_VAL;
        else if (i_DEC && (cnt_q != '0))
            cnt_q <= cnt_q - 1'b1;
    end

    assign o_ZERO = (cnt_q == '0);

endmodule

// File: rtl/level_sample_ctrl.sv
// Scheduled ADC sampling with hysteretic, debounced level decision.
// Optional REQ/ACK timeout enabled by defining LVL_TIMEOUT_EN.
module level_sample_ctrl
    import level_ctrl_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int CONFIRM = CONFIRM_DEF,
    parameter int TO_CYC  = TO_CYC_DEF
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_EN,
    input  logic [PER_W-1:0] i_PERIOD,
    input  logic [W-1:0]     i_TH_HI,
    input  logic [W-1:0]     i_TH_LO,
    output logic             o_REQ,
    input  logic             i_ACK,
    input  logic [W-1:0]     i_Lv,
    output logic [W-1:0]     o_SAMPLE,
    output logic             o_LEVEL,
    output logic             o_Pulse,
    output logic             o_TIMEOUT
);

    localparam int CW = $clog2(CONFIRM + 1);
    localparam logic [CW-1:0] CONF_V = CW'(CONFIRM);

    if (CONFIRM < 1 || TO_CYC < 1) begin : g_param_chk
        $error("level_sample_ctrl: CONFIRM and TO_CYC must be >= 1");
    end

    state_t         state_q, state_d;
    logic           tick_load, tick_dec, tick_zero;
    logic           capture, eval, to_cond;
    logic           qual, flip;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [W-1:0]   sample_q;
    logic           level_q, pulse_q, req_q;

    level_tick_gen u_tick (
        .i_CLK  (i_CLK),
        .i_RST  (i_RST),
        .i_LOAD (tick_load),
        .i_VAL  (period_reload(i_PERIOD)),
        .i_DEC  (tick_dec),
        .o_ZERO (tick_zero)
    );

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        tick_load = 1'b0;
        tick_dec  = 1'b0;
        capture   = 1'b0;
        eval      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_EN) begin
                    state_d   = WAIT;
                    tick_load = 1'b1;
                end
            end
            WAIT: begin
                if (!i_EN)
                    state_d = IDLE;
                else if (tick_zero)
                    state_d = REQ;
                else
                    tick_dec = 1'b1;
            end
            REQ: begin
                // An ACK on the expiry edge still wins over the timeout.
                if (i_ACK) begin
                    capture = 1'b1;
                    state_d = EVAL;
                end else if (to_cond) begin
                    state_d   = i_EN ? WAIT : IDLE;
                    tick_load = i_EN;
                end
            end
            EVAL: begin
                eval      = 1'b1;
                state_d   = i_EN ? WAIT : IDLE;
                tick_load = i_EN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Debounce: CONFIRM consecutive qualifying samples flip the level.
    always_comb begin
        qual    = eval && ((!level_q && (sample_q > i_TH_HI)) ||
                           ( level_q && (sample_q < i_TH_LO)));
        cnt_inc = (cnt_q == CONF_V) ? cnt_q : cnt_q + 1'b1;
        flip    = qual && (cnt_inc == CONF_V);
        cnt_d   = cnt_q;
        if (eval)
            cnt_d = (!qual || flip) ? '0 : cnt_inc;
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            req_q    <= 1'b0;
            sample_q <= '0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            req_q   <= (state_d == REQ);
            cnt_q   <= cnt_d;
            level_q <= level_q ^ flip;
            pulse_q <= flip && !level_q;
            if (capture)
                sample_q <= i_Lv;
        end
    end

`ifdef LVL_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    logic [TW-1:0] req_tmr_q;
    logic          timeout_q;

    // Counts completed REQ cycles; expiry lands on the TO_CYC-th edge.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST)
            req_tmr_q <= '0;
        else if (state_q == REQ)
            req_tmr_q <= req_tmr_q + 1'b1;
        else
            req_tmr_q <= '0;
    end

    assign to_cond = (state_q == REQ) && (req_tmr_q == TO_LAST);

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST)
            timeout_q <= 1'b0;
        else if (!i_EN)
            timeout_q <= 1'b0;
        else if (to_cond && !i_ACK)
            timeout_q <= 1'b1;
    end

    assign o_TIMEOUT = timeout_q;
`else
    assign to_cond   = 1'b0;
    assign o_TIMEOUT = 1'b0;
`endif

    assign o_REQ    = req_q;
    assign o_SAMPLE = sample_q;
    assign o_LEVEL  = level_q;
    assign o_Pulse  = pulse_q;

endmodule

// File: tb/tb_level_sample_ctrl.sv
// Randomized self-checking bench for level_sample_ctrl against a behavioural level model.
module tb_level_sample_ctrl;

    localparam int W       = 12;
    localparam int CONFIRM = 2;
    localparam int TO_CYC  = 8;

    logic          i_CLK = 1'b0;
    logic          i_RST = 1'b0;
    logic          i_EN  = 1'b0;
    logic [15:0]   i_PERIOD = 16'd4;
    logic [W-1:0]  i_TH_HI = 12'd2000;
    logic [W-1:0]  i_TH_LO = 12'd1800;
    logic          i_ACK = 1'b0;
    logic [W-1:0]  i_Lv  = '0;
    logic          o_REQ, o_LEVEL, o_Pulse, o_TIMEOUT;
    logic [W-1:0]  o_SAMPLE;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_rise = -1;
    bit noise  = 1'b0;

    // reference model state
    bit        m_level = 1'b0;
    int        m_cnt   = 0;
    int        m_sample = 0;

    level_sample_ctrl #(.W(W), .CONFIRM(CONFIRM), .TO_CYC(TO_CYC)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_EN(i_EN), .i_PERIOD(i_PERIOD),
        .i_TH_HI(i_TH_HI), .i_TH_LO(i_TH_LO), .o_REQ(o_REQ), .i_ACK(i_ACK),
        .i_Lv(i_Lv), .o_SAMPLE(o_SAMPLE), .o_LEVEL(o_LEVEL), .o_Pulse(o_Pulse),
        .o_TIMEOUT(o_TIMEOUT)
    );

    always #5 i_CLK = ~i_CLK;
    always @(posedge i_CLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    // Applies the threshold/debounce rules to one sample; returns expected pulse.
    task automatic model_eval(input int s, output bit pulse);
        bit q;
        q = (!m_level && s > int'(i_TH_HI)) || (m_level && s < int'(i_TH_LO));
        m_cnt = q ? m_cnt + 1 : 0;
        pulse = 1'b0;
        if (m_cnt >= CONFIRM) begin
            pulse   = !m_level;
            m_level = !m_level;
            m_cnt   = 0;
        end
    endtask

    task automatic enable();
        i_EN = 1'b1;
        exp_rise = cyc + 1 + ((i_PERIOD == 0) ? 1 : int'(i_PERIOD));
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            i_ACK = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            i_Lv  = W'($urandom_range(0, 4095));
            tick();
            checks++;
            if (o_Pulse !== 1'b0) begin
                errors++;
                $display("FAIL pulse_extra: got %b want 0 at cycle %0d", o_Pulse, cyc);
            end
            if (o_REQ === 1'b1) begin
                i_ACK = 1'b0;
                ok = 1'b1;
                return;
            end
        end
        i_ACK = 1'b0;
        errors++;
        $display("FAIL req_wait: o_REQ never rose within 300 cycles");
    endtask

    // One full request/ack transaction with cadence, capture and level checks.
    task automatic serve(input int dly, input int lv, input int per, input bit drop_en);
        bit ok, exp_p;
        int k;
        wait_req(ok);
        if (!ok) return;
        checks++;
        if (exp_rise >= 0 && cyc != exp_rise) begin
            errors++;
            $display("FAIL cadence: REQ rose at %0d want %0d", cyc, exp_rise);
        end
        if (drop_en) i_EN = 1'b0;
        repeat (dly) begin
            tick();
            checks++;
            if (o_REQ !== 1'b1) begin
                errors++;
                $display("FAIL req_hold: o_REQ=%b want 1", o_REQ);
            end
        end
        i_ACK = 1'b1;
        i_Lv  = W'(lv);
        i_PERIOD = 16'(per);
        tick();
        k = cyc;
        i_ACK = 1'b0;
        i_Lv  = W'($urandom_range(0, 4095));
        m_sample = lv;
        checks++;
        if (o_REQ !== 1'b0 || o_SAMPLE !== W'(m_sample)) begin
            errors++;
            $display("FAIL capture: req=%b sample=%0d want req=0 sample=%0d", o_REQ, o_SAMPLE, m_sample);
        end
        model_eval(lv, exp_p);
        tick();
        checks++;
        if (o_LEVEL !== m_level || o_Pulse !== exp_p) begin
            errors++;
            $display("FAIL eval: level=%b pulse=%b want level=%b pulse=%b (sample %0d)",
                     o_LEVEL, o_Pulse, m_level, exp_p, lv);
        end
        exp_rise = i_EN ? k + 1 + ((per == 0) ? 1 : per) : -1;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (o_REQ !== 1'b0 || o_SAMPLE !== '0 || o_LEVEL !== 1'b0 ||
            o_Pulse !== 1'b0 || o_TIMEOUT !== 1'b0) begin
            errors++;
            $display("FAIL %s: req=%b sample=%0d level=%b pulse=%b to=%b want all 0",
                     name, o_REQ, o_SAMPLE, o_LEVEL, o_Pulse, o_TIMEOUT);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        check_all_zero("reset_state");
        i_RST = 1'b1;
        tick();
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_cadence();
        i_PERIOD = 16'd4;
        enable();
        repeat (4) serve(0, 1000, 4, 1'b0);
        checks++;
        if (o_LEVEL !== 1'b0) begin
            errors++;
            $display("FAIL cadence_level: level=%b want 0", o_LEVEL);
        end
    endtask

    task automatic test_no_change();
        serve(0, 2100, 4, 1'b0);
        serve(1, 1900, 4, 1'b0);
        serve(0, 2100, 4, 1'b0);
        serve(0, 1000, 4, 1'b0);
        checks++;
        if (o_LEVEL !== 1'b0) begin
            errors++;
            $display("FAIL no_change: level=%b want 0", o_LEVEL);
        end
    endtask

    task automatic test_rise();
        serve(0, 2100, 4, 1'b0);
        serve(2, 2100, 4, 1'b0);
        checks++;
        if (o_LEVEL !== 1'b1 || o_Pulse !== 1'b1) begin
            errors++;
            $display("FAIL rise: level=%b pulse=%b want 1 1", o_LEVEL, o_Pulse);
        end
        tick();
        checks++;
        if (o_Pulse !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: pulse=%b want 0", o_Pulse);
        end
    endtask

    task automatic test_hysteresis();
        serve(0, 1900, 4, 1'b0);
        serve(0, 1900, 4, 1'b0);
        serve(0, 1800, 4, 1'b0);
        serve(0, 1800, 4, 1'b0);
        checks++;
        if (o_LEVEL !== 1'b1) begin
            errors++;
            $display("FAIL hyst_hold: level=%b want 1", o_LEVEL);
        end
        serve(0, 1700, 4, 1'b0);
        serve(0, 1700, 4, 1'b0);
        checks++;
        if (o_LEVEL !== 1'b0) begin
            errors++;
            $display("FAIL hyst_fall: level=%b want 0", o_LEVEL);
        end
        serve(0, 2000, 4, 1'b0);
        serve(0, 2000, 4, 1'b0);
        checks++;
        if (o_LEVEL !== 1'b0) begin
            errors++;
            $display("FAIL th_equal: level=%b want 0", o_LEVEL);
        end
    endtask

    task automatic test_back_to_back();
        serve(0, 1000, 0, 1'b0);
        for (int i = 0; i < 6; i++)
            serve(int'($urandom_range(0, 2)), int'($urandom_range(1600, 2300)), 0, 1'b0);
    endtask

    task automatic test_en_drop();
        i_PERIOD = 16'd3;
        serve(3, int'($urandom_range(1600, 2300)), 3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (o_REQ !== 1'b0) begin
                errors++;
                $display("FAIL en_drop_idle: req=%b want 0", o_REQ);
            end
        end
        enable();
        serve(0, 1000, 3, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit ok;
        i_PERIOD = 16'd2;
        serve(0, 2100, 2, 1'b0);
        serve(0, 2100, 2, 1'b0);
        serve(0, 2100, 2, 1'b0);
        wait_req(ok);
        #2;
        i_RST = 1'b0;
        #1;
        check_all_zero("reset_mid_req");
        m_level = 1'b0;
        m_cnt = 0;
        m_sample = 0;
        tick();
        i_RST = 1'b1;
        exp_rise = cyc + 1 + 2;
        serve(0, 1000, 2, 1'b0);
    endtask

    task automatic test_random();
        noise = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int lv;
            int sel;
            i_TH_HI = W'($urandom_range(1900, 2100));
            i_TH_LO = W'($urandom_range(1700, 1950));
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: lv = int'(i_TH_HI);
                1: lv = int'(i_TH_HI) + 1;
                2: lv = int'(i_TH_LO);
                3: lv = int'(i_TH_LO) - 1;
                default: lv = int'($urandom_range(1600, 2300));
            endcase
            serve(int'($urandom_range(0, 3)), lv, int'($urandom_range(0, 5)), 1'b0);
        end
        noise = 1'b0;
        i_TH_HI = 12'd2000;
        i_TH_LO = 12'd1800;
    endtask

`ifdef LVL_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        serve(0, 1000, 2, 1'b0);
        wait_req(ok);
        for (int i = 0; i < TO_CYC - 1; i++) begin
            tick();
            checks++;
            if (o_REQ !== 1'b1) begin
                errors++;
                $display("FAIL to_hold: req=%b want 1", o_REQ);
            end
        end
        tick();
        checks++;
        if (o_REQ !== 1'b0 || o_TIMEOUT !== 1'b1 || o_SAMPLE !== W'(m_sample)) begin
            errors++;
            $display("FAIL to_expire: req=%b to=%b sample=%0d want 0 1 %0d",
                     o_REQ, o_TIMEOUT, o_SAMPLE, m_sample);
        end
        exp_rise = cyc + 2;
        serve(0, 1000, 2, 1'b0);
        checks++;
        if (o_TIMEOUT !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky: to=%b want 1", o_TIMEOUT);
        end
        i_EN = 1'b0;
        tick();
        checks++;
        if (o_TIMEOUT !== 1'b0) begin
            errors++;
            $display("FAIL to_clear: to=%b want 0", o_TIMEOUT);
        end
        tick();
        enable();
        serve(TO_CYC - 1, 1234, 2, 1'b0);
        checks++;
        if (o_TIMEOUT !== 1'b0) begin
            errors++;
            $display("FAIL to_ack_wins: to=%b want 0", o_TIMEOUT);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cadence();
        test_no_change();
        test_rise();
        test_hysteresis();
        test_back_to_back();
        test_en_drop();
        test_reset_mid();
        test_random();
`ifdef LVL_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
